demux2_collect: RTL and testbench

Parametric bit demultiplexer/collector: the write-side counterpart of the `mux2` bit selector. It accepts a stream of single bits, each tagged with a `WLOG`-bit destination index, and deposits each bit into that position of a `2**WLOG`-bit word. The assembled word is emitted over a valid/ready handshake when every position has been written or the producer marks the last bit. It sits upstream of `mux2`-style read logic and rebuilds words that were serialised bit by bit.

---
 rtl/mux_pkg.sv | 13 +
 rtl/onehot_dec.sv | 17 +
 rtl/demux2_collect.sv | 96 +++++++++
 tb/tb_demux2_collect.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and constants for the mux2 / demux2_collect family
package mux_pkg;

    // Word collector states: filling the word, or holding it for the consumer
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // log2 of the word width used by mux2 and demux2_collect unless overridden
    localparam int WLOG_DEFAULT = 3;

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - binary index to one-hot write-enable decoder
module onehot_dec
    import mux_pkg::*;
#(
    parameter int WLOG = WLOG_DEFAULT
) (
    input  logic [WLOG-1:0]      sel,
    output logic [(1<<WLOG)-1:0] onehot
);

    // Exactly one enable bit set, at the selected position
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/demux2_collect.sv
// rtl/demux2_collect.sv - collects indexed single bits into a word and emits it on a valid/ready handshake
module demux2_collect
    import mux_pkg::*;
#(
    parameter int WLOG = WLOG_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_bit,
    input  logic [WLOG-1:0]      in_sel,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [(1<<WLOG)-1:0] out_word,
    output logic [(1<<WLOG)-1:0] out_word_n,
    output logic [(1<<WLOG)-1:0] out_mask,
    output logic                 dup_err
);

    localparam int W = 1 << WLOG;

    state_t         state;
    logic [W-1:0]   word;
    logic [W-1:0]   mask;
    logic [W-1:0]   we;
    logic           accept;
    logic           dup_hit;
    logic           full_next;
    logic           close_word;

    onehot_dec #(.WLOG(WLOG)) u_dec (
        .sel    (in_sel),
        .onehot (we)
    );

    // Accept qualification and the two word-closing conditions
    always_comb begin
        accept     = (state == COLLECT) && in_valid;
        dup_hit    = |(mask & we);
        full_next  = &(mask | we);
        close_word = accept && (full_next || in_last);
    end

    // Outputs come straight from the held registers; the complement is tied to the word
    assign out_word   = word;
    assign out_word_n = ~word;
    assign out_mask   = mask;

    // Collector FSM with word/mask storage, handshake flags and duplicate-write flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            word      <= '0;
            mask      <= '0;
            dup_err   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    dup_err <= accept && dup_hit;
                    if (accept) begin
                        word <= (word & ~we) | ({W{in_bit}} & we);
                        mask <= mask | we;
                    end
                    if (close_word) begin
                        state     <= HOLD;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    dup_err <= 1'b0;
                    if (out_ready) begin
                        state     <= COLLECT;
                        word      <= '0;
                        mask      <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= COLLECT;
                    word      <= '0;
                    mask      <= '0;
                    dup_err   <= 1'b0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux2_collect.sv
// tb/tb_demux2_collect.sv - self-checking bench for demux2_collect at WLOG 3, 1 and 4
module tb_demux2_collect;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] iv, ib, il, ordy;
    logic [2:0] ir, ov, de;
    logic [3:0] sel [3];

    logic [2:0]  is0;
    logic [0:0]  is1;
    logic [3:0]  is2;
    logic [7:0]  ow0, own0, om0;
    logic [1:0]  ow1, own1, om1;
    logic [15:0] ow2, own2, om2;
    logic [15:0] aw [3];
    logic [15:0] awn [3];
    logic [15:0] am [3];

    int total = 0;
    int bad   = 0;

    // model state per instance: index 0 -> WLOG 3, 1 -> WLOG 1, 2 -> WLOG 4
    int        wd [3] = '{8, 2, 16};
    bit        hold_m [3];
    bit [15:0] val_m [3];
    bit [15:0] wr_m [3];
    bit        dup_m [3];
    bit        model_ok = 1'b0;

    always #5 clk = ~clk;

    assign is0 = sel[0][2:0];
    assign is1 = sel[1][0:0];
    assign is2 = sel[2];

    always_comb begin
        aw[0]  = {8'h00, ow0};   awn[0] = {8'h00, own0};   am[0] = {8'h00, om0};
        aw[1]  = {14'h0, ow1};   awn[1] = {14'h0, own1};   am[1] = {14'h0, om1};
        aw[2]  = ow2;            awn[2] = own2;            am[2] = om2;
    end

    demux2_collect #(.WLOG(3)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_bit(ib[0]),
        .in_sel(is0), .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_word(ow0), .out_word_n(own0), .out_mask(om0), .dup_err(de[0])
    );

    demux2_collect #(.WLOG(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_bit(ib[1]),
        .in_sel(is1), .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_word(ow1), .out_word_n(own1), .out_mask(om1), .dup_err(de[1])
    );

    demux2_collect #(.WLOG(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_bit(ib[2]),
        .in_sel(is2), .in_last(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_word(ow2), .out_word_n(own2), .out_mask(om2), .dup_err(de[2])
    );

    function automatic bit [15:0] full_of(int w);
        return 16'((32'h1 << w) - 1);
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: set of written positions and their values, plus a held flag
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                hold_m[k] = 1'b0;
                val_m[k]  = '0;
                wr_m[k]   = '0;
                dup_m[k]  = 1'b0;
            end
            model_ok = 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                int s;
                dup_m[k] = 1'b0;
                if (!hold_m[k]) begin
                    if (iv[k]) begin
                        s = int'(sel[k]) % wd[k];
                        if (wr_m[k][s]) dup_m[k] = 1'b1;
                        wr_m[k][s]  = 1'b1;
                        val_m[k][s] = ib[k];
                        if (wr_m[k] == full_of(wd[k]) || il[k]) hold_m[k] = 1'b1;
                    end
                end else if (ordy[k]) begin
                    hold_m[k] = 1'b0;
                    val_m[k]  = '0;
                    wr_m[k]   = '0;
                end
            end
        end
    end

    // compare every instance against the model on every falling edge
    always @(negedge clk) begin
        if (model_ok) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("in_ready[%0d]", k),   {15'h0, ir[k]}, {15'h0, !hold_m[k]});
                chk($sformatf("out_valid[%0d]", k),  {15'h0, ov[k]}, {15'h0, hold_m[k]});
                chk($sformatf("out_word[%0d]", k),   aw[k],  val_m[k]);
                chk($sformatf("out_word_n[%0d]", k), awn[k], ~val_m[k] & full_of(wd[k]));
                chk($sformatf("out_mask[%0d]", k),   am[k],  wr_m[k]);
                chk($sformatf("dup_err[%0d]", k),    {15'h0, de[k]}, {15'h0, dup_m[k]});
            end
        end
    end

    task automatic drive(int k, bit v, int s, bit b, bit last);
        iv[k]  = v;
        sel[k] = 4'(s);
        ib[k]  = b;
        il[k]  = last;
        @(negedge clk);
    endtask

    initial begin
        bit [7:0] pat;
        rst  = 1'b1;
        iv   = '0;
        ib   = '0;
        il   = '0;
        ordy = 3'b111;
        for (int k = 0; k < 3; k++) sel[k] = '0;
        @(negedge clk);

        // reset values
        chk("rst_in_ready",   {15'h0, ir[0]}, 16'h0001);
        chk("rst_out_valid",  {15'h0, ov[0]}, 16'h0000);
        chk("rst_out_word",   aw[0],  16'h0000);
        chk("rst_out_word_n", awn[0], 16'h00FF);
        chk("rst_out_mask",   am[0],  16'h0000);
        chk("rst_dup_err",    {15'h0, de[0]}, 16'h0000);
        rst = 1'b0;

        // full word 8'hA5, LSB first
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) drive(0, 1'b1, i, pat[i], 1'b0);
        chk("full_out_valid", {15'h0, ov[0]}, 16'h0001);
        chk("full_in_ready",  {15'h0, ir[0]}, 16'h0000);
        chk("full_word",      aw[0],  16'h00A5);
        chk("full_word_n",    awn[0], 16'h005A);
        chk("full_mask",      am[0],  16'h00FF);
        chk("model_full_word", val_m[0], 16'h00A5);
        chk("model_full_mask", wr_m[0],  16'h00FF);
        drive(0, 1'b0, 0, 1'b0, 1'b0);
        chk("full_in_ready_back", {15'h0, ir[0]}, 16'h0001);
        chk("full_mask_cleared",  am[0], 16'h0000);

        // partial word closed by in_last
        drive(0, 1'b1, 3, 1'b1, 1'b0);
        drive(0, 1'b1, 6, 1'b1, 1'b1);
        chk("part_out_valid", {15'h0, ov[0]}, 16'h0001);
        chk("part_word",      aw[0], 16'h0048);
        chk("part_mask",      am[0], 16'h0048);
        chk("model_part_word", val_m[0], 16'h0048);
        drive(0, 1'b0, 0, 1'b0, 1'b0);

        // duplicate index
        drive(0, 1'b1, 2, 1'b1, 1'b0);
        drive(0, 1'b1, 2, 1'b0, 1'b0);
        chk("dup_pulse", {15'h0, de[0]}, 16'h0001);
        drive(0, 1'b1, 0, 1'b1, 1'b1);
        chk("dup_pulse_end", {15'h0, de[0]}, 16'h0000);
        chk("dup_word",      aw[0], 16'h0001);
        chk("dup_mask",      am[0], 16'h0005);
        drive(0, 1'b0, 0, 1'b0, 1'b0);

        // backpressure with in_valid held high
        ordy[0] = 1'b0;
        for (int i = 0; i < 8; i++) drive(0, 1'b1, i, 1'b1, 1'b0);
        for (int r = 0; r < 5; r++) begin
            chk("bp_in_ready",  {15'h0, ir[0]}, 16'h0000);
            chk("bp_out_valid", {15'h0, ov[0]}, 16'h0001);
            chk("bp_word",      aw[0], 16'h00FF);
            chk("bp_mask",      am[0], 16'h00FF);
            drive(0, 1'b1, 0, 1'b0, 1'b0);
        end
        ordy[0] = 1'b1;
        drive(0, 1'b0, 0, 1'b0, 1'b0);
        chk("bp_release_ready", {15'h0, ir[0]}, 16'h0001);
        chk("bp_release_mask",  am[0], 16'h0000);

        // reset mid-word
        for (int i = 0; i < 4; i++) drive(0, 1'b1, i, 1'b1, 1'b0);
        rst = 1'b1;
        drive(0, 1'b0, 0, 1'b0, 1'b0);
        chk("mid_rst_in_ready",  {15'h0, ir[0]}, 16'h0001);
        chk("mid_rst_out_valid", {15'h0, ov[0]}, 16'h0000);
        chk("mid_rst_word",      aw[0],  16'h0000);
        chk("mid_rst_word_n",    awn[0], 16'h00FF);
        chk("mid_rst_mask",      am[0],  16'h0000);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) drive(0, 1'b1, i, (i < 4), 1'b0);
        chk("post_rst_word", aw[0], 16'h000F);
        chk("post_rst_mask", am[0], 16'h00FF);
        drive(0, 1'b0, 0, 1'b0, 1'b0);

        // random sweep on all three widths, checked by the model
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 3; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                sel[k]  = 4'($urandom_range(0, wd[k] - 1));
                ib[k]   = 1'($urandom);
                il[k]   = ($urandom_range(0, 7) == 0);
                ordy[k] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        rst  = 1'b0;
        iv   = '0;
        ordy = 3'b111;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
